// File: rtl/nlms_weight_update.sv
// rtl/nlms_weight_update.sv - NLMS coefficient update: serial gain divide, then one tap MAC per cycle
// Holds the filter coefficients; each start computes w_k += mu*e*x_k/n across all taps.
module nlms_weight_update #(
  parameter int TAPS     = 32,
  parameter int MU_SHIFT = 4,
  parameter int GFRAC    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clr,
  input  logic signed [13:0]     e,
  input  logic [31:0]            n,
  input  logic [TAPS*14-1:0]     x_taps,
  output logic [TAPS*32-1:0]     weights,
  output logic                   busy,
  output logic                   done,
  output logic                   div_err
);

  localparam int KW         = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CW         = (KW > 6) ? KW : 6;
  localparam int DIV_CYCLES = 40;
  localparam int SH         = GFRAC + MU_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_UPD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                e_neg_q, e_neg_d;
  logic [31:0]         n_q, n_d;
  logic [TAPS*14-1:0]  x_q, x_d;
  logic [39:0]         nq_q, nq_d;
  logic [31:0]         rem_q, rem_d;
  logic                div_err_q, div_err_d;
  logic signed [31:0]  w_q [TAPS];
  logic signed [31:0]  w_d [TAPS];

  logic [13:0]         e_mag_in;
  logic [32:0]         rem_sh;
  logic [31:0]         rem_sub;
  logic                q_bit;
  logic [30:0]         q_sat;
  logic [31:0]         g_mag;
  logic signed [31:0]  g;
  logic [KW-1:0]       tap_idx;
  logic signed [13:0]  x_k;
  logic signed [31:0]  w_cur;
  logic signed [45:0]  prod;
  logic signed [45:0]  delta;
  logic signed [46:0]  sum;
  logic                ovf_pos, ovf_neg;
  logic signed [31:0]  w_upd;

  // Numerator bits shift out of the top of nq while quotient bits shift in at the bottom.
  assign e_mag_in = e[13] ? (~e + 14'd1) : e;
  assign rem_sh   = {rem_q, nq_q[39]};
  assign rem_sub  = rem_sh[31:0] - n_q;
  assign q_bit    = (rem_sh >= {1'b0, n_q});

  assign q_sat    = (|nq_q[39:31]) ? 31'h7FFF_FFFF : nq_q[30:0];
  assign g_mag    = {1'b0, q_sat};
  assign g        = e_neg_q ? -g_mag : g_mag;

  assign tap_idx  = cnt_q[KW-1:0];
  assign x_k      = x_q[14*tap_idx +: 14];
  assign w_cur    = w_q[tap_idx];
  assign prod     = 46'(g) * 46'(x_k);
  assign delta    = prod >>> SH;
  assign sum      = 47'(w_cur) + 47'(delta);
  assign ovf_pos  = !sum[46] && (|sum[45:31]);
  assign ovf_neg  = sum[46] && !(&sum[45:31]);

  always_comb begin
    w_upd = sum[31:0];
    if (ovf_pos) w_upd = 32'sh7FFF_FFFF;
    else if (ovf_neg) w_upd = 32'sh8000_0000;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    e_neg_d   = e_neg_q;
    n_d       = n_q;
    x_d       = x_q;
    nq_d      = nq_q;
    rem_d     = rem_q;
    div_err_d = div_err_q;
    for (int k = 0; k < TAPS; k++) w_d[k] = w_q[k];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          e_neg_d   = e[13];
          n_d       = n;
          x_d       = x_taps;
          nq_d      = 40'(e_mag_in) << (10 + GFRAC);
          rem_d     = '0;
          cnt_d     = '0;
          div_err_d = 1'b0;
          state_d   = S_DIV;
        end else if (clr) begin
          for (int k = 0; k < TAPS; k++) w_d[k] = '0;
        end
      end
      S_DIV: begin
        nq_d  = {nq_q[38:0], q_bit};
        rem_d = q_bit ? rem_sub : rem_sh[31:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DIV_CYCLES - 1)) begin
          cnt_d = '0;
          if (n_q == 32'd0) begin
            div_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_UPD;
          end
        end
      end
      S_UPD: begin
        w_d[tap_idx] = w_upd;
        cnt_d        = cnt_q + CW'(1);
        if (tap_idx == KW'(TAPS - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      e_neg_q   <= 1'b0;
      n_q       <= '0;
      x_q       <= '0;
      nq_q      <= '0;
      rem_q     <= '0;
      div_err_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) w_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      e_neg_q   <= e_neg_d;
      n_q       <= n_d;
      x_q       <= x_d;
      nq_q      <= nq_d;
      rem_q     <= rem_d;
      div_err_q <= div_err_d;
      for (int k = 0; k < TAPS; k++) w_q[k] <= w_d[k];
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_w_out
    assign weights[32*k +: 32] = w_q[k];
  end

  assign busy    = (state_q == S_DIV) || (state_q == S_UPD);
  assign done    = (state_q == S_DONE);
  assign div_err = div_err_q;

endmodule

// File: tb/tb_nlms_weight_update.sv
// tb/tb_nlms_weight_update.sv - scoreboard bench for nlms_weight_update against an arithmetic NLMS model
module tb_nlms_weight_update;
  localparam int TAPS = 32;

  logic                   clk = 1'b0;
  logic                   rst, start, clr;
  logic signed [13:0]     e;
  logic [31:0]            n;
  logic [TAPS*14-1:0]     x_taps;
  logic [TAPS*32-1:0]     weights;
  logic                   busy, done, div_err;

  nlms_weight_update #(.TAPS(TAPS), .MU_SHIFT(4), .GFRAC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .e(e), .n(n),
    .x_taps(x_taps), .weights(weights), .busy(busy), .done(done), .div_err(div_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, done_cnt = 0;

  typedef struct {
    logic [TAPS*32-1:0] w;
    bit                 derr;
    int                 t0;
    int                 lat;
  } exp_t;
  exp_t   sbq[$];
  longint wm[TAPS];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [TAPS*32-1:0] pack_model();
    logic [TAPS*32-1:0] r;
    for (int k = 0; k < TAPS; k++) r[32*k +: 32] = wm[k][31:0];
    return r;
  endfunction

  function automatic logic [TAPS*14-1:0] rand_x();
    logic [TAPS*14-1:0] r;
    for (int k = 0; k < TAPS; k++) r[14*k +: 14] = 14'($urandom);
    return r;
  endfunction

  // Gain is the exact integer quotient of |e|*2^26/n, saturated, then each tap gets floor(g*x/2^20).
  task automatic model_op(input logic signed [13:0] ev, input logic [31:0] nv,
                          input logic [TAPS*14-1:0] xv, output bit derr);
    longint mag, q, g, xk, s;
    derr = (nv == 32'd0);
    if (derr) return;
    mag = longint'(ev);
    if (mag < 0) mag = -mag;
    q = (mag * 64'sd67108864) / longint'(nv);
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    g = (ev < 0) ? -q : q;
    for (int k = 0; k < TAPS; k++) begin
      xk = longint'($signed(xv[14*k +: 14]));
      s  = wm[k] + ((g * xk) >>> 20);
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
      wm[k] = s;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t ex;
    int   bad;
    if (!rst && done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 required no done (cycle %0d)", cyc);
      end else begin
        ex  = sbq.pop_front();
        bad = -1;
        for (int k = TAPS - 1; k >= 0; k--)
          if (weights[32*k +: 32] !== ex.w[32*k +: 32]) bad = k;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL done_weights: tap %0d got %0d expected %0d", bad,
                   $signed(weights[32*bad +: 32]), $signed(ex.w[32*bad +: 32]));
        end
        chk("done_latency", longint'(cyc - ex.t0), longint'(ex.lat));
        chk("done_div_err", longint'(div_err), longint'(ex.derr));
        chk("done_busy_low", longint'(busy), 0);
      end
    end
  end

  // mode 0 plain, 1 trace per-tap write timing, 2 start while busy, 3 clr while busy
  task automatic run_op(input logic signed [13:0] ev, input logic [31:0] nv,
                        input logic [TAPS*14-1:0] xv, input int mode);
    longint pre[TAPS];
    bit     derr;
    int     t0, c, d0;
    exp_t   ex;
    for (int k = 0; k < TAPS; k++) pre[k] = wm[k];
    model_op(ev, nv, xv, derr);
    @(negedge clk);
    e = ev; n = nv; x_taps = xv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    d0 = done_cnt;
    ex.w = pack_model(); ex.derr = derr; ex.t0 = t0; ex.lat = derr ? 40 : 72;
    sbq.push_back(ex);
    chk("busy_after_start", longint'(busy), 1);
    e = 14'($urandom); n = $urandom; x_taps = rand_x();
    c = 0;
    while (done_cnt == d0 && c < 200) begin
      @(negedge clk);
      c = cyc - t0;
      if (mode == 1)
        for (int k = 0; k < TAPS; k++) begin
          if (c == 40 + k) chk("tap_before_write", longint'($signed(weights[32*k +: 32])), pre[k]);
          if (c == 41 + k) chk("tap_after_write", longint'($signed(weights[32*k +: 32])), wm[k]);
        end
      if (mode == 2) start = (c == 10);
      if (mode == 3) clr = (c == 20);
    end
    start = 1'b0;
    clr   = 1'b0;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL op_timeout: got no done within 200 cycles, required done");
    end
    repeat (2) @(negedge clk);
    if (mode == 2) repeat (80) @(negedge clk);
    chk("single_done", longint'(done_cnt - d0), 1);
    chk("idle_busy_low", longint'(busy), 0);
  endtask

  initial begin
    logic [TAPS*14-1:0] xv;
    int                 t0, d0, sel;
    logic [31:0]        nv;
    rst = 1'b1; start = 1'b0; clr = 1'b0; e = '0; n = '0; x_taps = '0;
    for (int k = 0; k < TAPS; k++) wm[k] = 0;
    repeat (3) @(negedge clk);
    chk("reset_weights_zero", longint'(weights == '0), 1);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_div_err", longint'(div_err), 0);
    rst = 1'b0;

    run_op(14'sd0, 32'd5, rand_x(), 0);
    chk("e_zero_weights", longint'(weights == '0), 1);

    xv = '0; xv[13:0] = 14'd16;
    run_op(14'sd1024, 32'd1024, xv, 0);
    chk("unit_step_w0", longint'($signed(weights[31:0])), 1024);
    run_op(-14'sd1024, 32'd1024, xv, 0);
    chk("unit_step_back_w0", longint'($signed(weights[31:0])), 0);

    for (int k = 0; k < TAPS; k++) xv[14*k +: 14] = 14'(16 * (k + 1));
    run_op(14'sd1024, 32'd1024, xv, 1);
    chk("tap_map_w31", longint'($signed(weights[32*31 +: 32])), 1024 * 32);

    run_op(14'sd100, 32'd0, rand_x(), 0);
    chk("div_err_held", longint'(div_err), 1);
    chk("div0_w5_kept", longint'($signed(weights[32*5 +: 32])), 1024 * 6);
    run_op(14'sd5, 32'd1, rand_x(), 0);
    chk("div_err_cleared", longint'(div_err), 0);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int k = 0; k < TAPS; k++) wm[k] = 0;
    chk("clr_idle_zero", longint'(weights == '0), 1);

    run_op(14'($urandom), 32'd300, rand_x(), 0);
    run_op(14'($urandom), 32'd777, rand_x(), 2);
    run_op(14'($urandom), 32'd50, rand_x(), 3);

    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: nv = $urandom_range(1, 4096);
        1: nv = $urandom;
        2: nv = 32'd0;
        default: nv = $urandom_range(1, 1 << 20);
      endcase
      run_op(14'($urandom), nv, rand_x(), 0);
    end

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int k = 0; k < TAPS; k++) wm[k] = 0;
    xv = '0; xv[13:0] = 14'd8191;
    for (int r = 0; r < 128; r++) run_op(14'sd8191, 32'd1, xv, 0);
    chk("sat_w0_128", longint'($signed(weights[31:0])), 64'sd2147221376);
    run_op(14'sd8191, 32'd1, xv, 0);
    chk("sat_w0_129", longint'($signed(weights[31:0])), 64'sd2147483647);

    @(negedge clk);
    e = 14'sd500; n = 32'd7; x_taps = rand_x(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    d0 = done_cnt;
    while (cyc - t0 < 49 && cyc - t0 < 200) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_weights_zero", longint'(weights == '0), 1);
    chk("rst_mid_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) wm[k] = 0;
    repeat (100) @(negedge clk);
    chk("rst_mid_no_done", longint'(done_cnt - d0), 0);
    chk("scoreboard_drained", longint'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
